// File: rtl/ctrl_fsm_param.sv
// Fetch/decode/execute control FSM driving PC, IR, register file, ALU and data memory.
// Outputs are decoded combinationally from the current state and ir; LOAD waits LOAD_LAT cycles.
module ctrl_fsm_param #(
   parameter int IW       = 16,
   parameter int RF_AW    = 4,
   parameter int DM_AW    = 8,
   parameter int PC_AW    = 7,
   parameter int LOAD_LAT = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IW-1:0]    ir,
   input  logic             ra_zero,
   input  logic             resume,
   output logic             PC_clr,
   output logic             PC_up,
   output logic             PC_ld,
   output logic [PC_AW-1:0] PC_addr,
   output logic             IR_ld,
   output logic [DM_AW-1:0] D_addr,
   output logic             D_wr,
   output logic             RF_s,
   output logic [RF_AW-1:0] RF_W_addr,
   output logic             RF_W_en,
   output logic [RF_AW-1:0] RF_Ra_addr,
   output logic [RF_AW-1:0] RF_Rb_addr,
   output logic [2:0]       ALU_s0,
   output logic             halted,
   output logic             illegal,
   output logic [3:0]       state_cur,
   output logic [3:0]       state_nxt
);

   localparam int CW = (LOAD_LAT < 2) ? 1 : $clog2(LOAD_LAT + 1);

   typedef enum logic [3:0] {
      INIT   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  NOOP  = 4'd3,
      LOAD_A = 4'd4,  LOAD_B = 4'd5,  STORE  = 4'd6,  ADD   = 4'd7,
      SUB    = 4'd8,  HALT   = 4'd9,  JMP    = 4'd10, JZ    = 4'd11
   } state_t;

   state_t        st, nx;
   logic [CW-1:0] cnt;

   logic [3:0]       op;
   logic [RF_AW-1:0] fa, fb, fw;
   logic [DM_AW-1:0] ld_addr, st_addr;
   logic [PC_AW-1:0] target;

   assign op      = ir[IW-1 -: 4];
   assign fa      = ir[IW-5 -: RF_AW];
   assign fb      = ir[IW-5-RF_AW -: RF_AW];
   assign fw      = ir[RF_AW-1:0];
   assign ld_addr = ir[RF_AW +: DM_AW];
   assign st_addr = ir[DM_AW-1:0];
   assign target  = ir[PC_AW-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st  <= INIT;
         cnt <= '0;
      end else begin
         st  <= nx;
         // counter restarts whenever LOAD_A is (re)entered
         if (st == LOAD_A && nx == LOAD_A) cnt <= cnt + 1'b1;
         else                              cnt <= '0;
      end
   end

   always_comb begin
      nx         = INIT;
      PC_clr     = 1'b0;
      PC_up      = 1'b0;
      PC_ld      = 1'b0;
      PC_addr    = '0;
      IR_ld      = 1'b0;
      D_addr     = '0;
      D_wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_addr  = '0;
      RF_W_en    = 1'b0;
      RF_Ra_addr = '0;
      RF_Rb_addr = '0;
      ALU_s0     = 3'd0;
      halted     = 1'b0;
      illegal    = 1'b0;
      case (st)
         INIT: begin
            PC_clr = 1'b1;
            nx     = FETCH;
         end
         FETCH: begin
            PC_up = 1'b1;
            IR_ld = 1'b1;
            nx    = DECODE;
         end
         DECODE: begin
            case (op)
               4'd0:    nx = NOOP;
               4'd1:    nx = STORE;
               4'd2:    nx = LOAD_A;
               4'd3:    nx = ADD;
               4'd4:    nx = SUB;
               4'd5:    nx = HALT;
               4'd6:    nx = JMP;
               4'd7:    nx = JZ;
               default: begin
                  nx      = NOOP;
                  illegal = 1'b1;
               end
            endcase
         end
         NOOP: nx = FETCH;
         LOAD_A: begin
            D_addr    = ld_addr;
            RF_s      = 1'b1;
            RF_W_addr = fw;
            nx        = (cnt == CW'(LOAD_LAT - 1)) ? LOAD_B : LOAD_A;
         end
         LOAD_B: begin
            D_addr    = ld_addr;
            RF_s      = 1'b1;
            RF_W_addr = fw;
            RF_W_en   = 1'b1;
            nx        = FETCH;
         end
         STORE: begin
            D_addr     = st_addr;
            D_wr       = 1'b1;
            RF_Ra_addr = fa;
            nx         = FETCH;
         end
         ADD, SUB: begin
            RF_Ra_addr = fa;
            RF_Rb_addr = fb;
            RF_W_addr  = fw;
            RF_W_en    = 1'b1;
            ALU_s0     = (st == ADD) ? 3'd1 : 3'd2;
            nx         = FETCH;
         end
         HALT: begin
            halted = 1'b1;
            nx     = resume ? FETCH : HALT;
         end
         JMP: begin
            PC_ld   = 1'b1;
            PC_addr = target;
            nx      = FETCH;
         end
         JZ: begin
            RF_Ra_addr = fa;
            if (ra_zero) begin
               PC_ld   = 1'b1;
               PC_addr = target;
            end
            nx = FETCH;
         end
         default: nx = INIT;
      endcase
   end

   assign state_cur = st;
   assign state_nxt = nx;

endmodule

// File: tb/tb_ctrl_fsm_param.sv
// Bench for ctrl_fsm_param (LOAD_LAT=3): each instruction is expanded into its expected
// per-cycle control trace and compared against the DUT outputs.
module tb_ctrl_fsm_param;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] ir;
   logic        ra_zero, resume;
   logic        PC_clr, PC_up, PC_ld, IR_ld, D_wr, RF_s, RF_W_en, halted, illegal;
   logic [6:0]  PC_addr;
   logic [7:0]  D_addr;
   logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, state_cur, state_nxt;
   logic [2:0]  ALU_s0;

   typedef struct packed {
      logic [3:0] st;
      logic [3:0] nx;
      logic       pc_clr, pc_up, pc_ld;
      logic [6:0] pc_addr;
      logic       ir_ld;
      logic [7:0] d_addr;
      logic       d_wr, rf_s;
      logic [3:0] w_addr;
      logic       w_en;
      logic [3:0] ra, rb;
      logic [2:0] alu;
      logic       halted, illegal;
   } obs_t;

   obs_t obs;
   obs_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   ctrl_fsm_param #(.IW(16), .RF_AW(4), .DM_AW(8), .PC_AW(7), .LOAD_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .ir(ir), .ra_zero(ra_zero), .resume(resume),
      .PC_clr(PC_clr), .PC_up(PC_up), .PC_ld(PC_ld), .PC_addr(PC_addr), .IR_ld(IR_ld),
      .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s), .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
      .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .ALU_s0(ALU_s0), .halted(halted),
      .illegal(illegal), .state_cur(state_cur), .state_nxt(state_nxt)
   );

   always #5 clk = ~clk;

   assign obs = {state_cur, state_nxt, PC_clr, PC_up, PC_ld, PC_addr, IR_ld, D_addr, D_wr,
                 RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, halted, illegal};

   // Called at posedge+1; compares mid-cycle, returns at the next posedge+1.
   task automatic check_cycle(input obs_t e, input string tag);
      @(negedge clk);
      total++;
      assert (obs === e) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
      @(posedge clk);
      #1;
   endtask

   function automatic obs_t init_exp();
      obs_t e = '0;
      e.st = 4'd0; e.nx = 4'd1; e.pc_clr = 1'b1;
      return e;
   endfunction

   // Instruction-level model: what each cycle of one instruction must look like.
   function automatic void build(input logic [15:0] v, input logic rz);
      int   op  = int'(v) / 4096;
      int   a   = (int'(v) / 256) % 16;
      int   b   = (int'(v) / 16) % 16;
      int   w   = int'(v) % 16;
      int   lda = (int'(v) / 16) % 256;
      int   sta = int'(v) % 256;
      int   tgt = int'(v) % 128;
      int   dst;
      obs_t e;
      exp_q.delete();
      e = '0; e.st = 4'd1; e.nx = 4'd2; e.pc_up = 1'b1; e.ir_ld = 1'b1;
      exp_q.push_back(e);
      case (op)
         1: dst = 6;   2: dst = 4;   3: dst = 7;   4: dst = 8;
         5: dst = 9;   6: dst = 10;  7: dst = 11;  default: dst = 3;
      endcase
      e = '0; e.st = 4'd2; e.nx = 4'(dst); e.illegal = (op >= 8);
      exp_q.push_back(e);
      e = '0; e.nx = 4'd1;
      case (op)
         1: begin
            e.st = 4'd6; e.d_addr = 8'(sta); e.d_wr = 1'b1; e.ra = 4'(a);
            exp_q.push_back(e);
         end
         2: begin
            for (int i = 0; i < LAT; i++) begin
               e.st = 4'd4; e.d_addr = 8'(lda); e.rf_s = 1'b1; e.w_addr = 4'(w);
               e.nx = (i == LAT - 1) ? 4'd5 : 4'd4;
               exp_q.push_back(e);
            end
            e.st = 4'd5; e.w_en = 1'b1; e.nx = 4'd1;
            exp_q.push_back(e);
         end
         3, 4: begin
            e.st = (op == 3) ? 4'd7 : 4'd8; e.ra = 4'(a); e.rb = 4'(b); e.w_addr = 4'(w);
            e.w_en = 1'b1; e.alu = (op == 3) ? 3'd1 : 3'd2;
            exp_q.push_back(e);
         end
         5: ;
         6: begin
            e.st = 4'd10; e.pc_ld = 1'b1; e.pc_addr = 7'(tgt);
            exp_q.push_back(e);
         end
         7: begin
            e.st = 4'd11; e.ra = 4'(a);
            if (rz) begin e.pc_ld = 1'b1; e.pc_addr = 7'(tgt); end
            exp_q.push_back(e);
         end
         default: begin
            e.st = 4'd3;
            exp_q.push_back(e);
         end
      endcase
   endfunction

   task automatic run_instr(input logic [15:0] v, input logic rz, input string tag);
      ir = v; ra_zero = rz; resume = 1'($urandom % 2);
      build(v, rz);
      foreach (exp_q[i]) check_cycle(exp_q[i], tag);
   endtask

   initial begin
      obs_t h;
      logic [3:0] op;
      reset = 1'b1; ir = 16'h0000; ra_zero = 1'b0; resume = 1'b0;
      #1;
      check_cycle(init_exp(), "reset_held");
      reset = 1'b0;
      check_cycle(init_exp(), "init");
      run_instr(16'h0000, 1'b0, "noop1");
      run_instr(16'h0000, 1'b0, "noop2");
      run_instr(16'h1F29, 1'b0, "store");
      run_instr(16'h20A7, 1'b0, "load");
      run_instr(16'h3123, 1'b0, "add");
      run_instr(16'h4123, 1'b1, "sub");
      run_instr(16'h7115, 1'b1, "jz_taken");
      run_instr(16'h7115, 1'b0, "jz_not");
      run_instr(16'h9000, 1'b0, "illegal");
      run_instr(16'hF0FF, 1'b1, "illegal_f");
      run_instr(16'h6055, 1'b0, "jmp");

      // HALT: resume high during FETCH/DECODE must be ignored
      ir = 16'h5000; ra_zero = 1'b0; resume = 1'b1;
      build(16'h5000, 1'b0);
      foreach (exp_q[i]) check_cycle(exp_q[i], "halt_entry");
      resume = 1'b0;
      h = '0; h.st = 4'd9; h.nx = 4'd9; h.halted = 1'b1;
      repeat (10) check_cycle(h, "halt_hold");
      resume = 1'b1; h.nx = 4'd1;
      check_cycle(h, "halt_resume");
      run_instr(16'h0000, 1'b0, "after_halt");

      // reset in the middle of LOAD_A: back to INIT, the load never writes
      ir = 16'h20A7; ra_zero = 1'b0; resume = 1'b0;
      build(16'h20A7, 1'b0);
      for (int i = 0; i < 3; i++) check_cycle(exp_q[i], "load_pre_reset");
      reset = 1'b1;
      #2;
      reset = 1'b0;
      check_cycle(init_exp(), "mid_load_reset");
      run_instr(16'h0000, 1'b0, "post_reset");
      run_instr(16'h2F31, 1'b0, "load_after_reset");

      for (int n = 0; n < 150; n++) begin
         op = 4'($urandom % 16);
         if (op == 4'd5) op = 4'd0;
         run_instr({op, 12'($urandom)}, 1'($urandom % 2), "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
